vga_sync_gen: RTL and testbench
===============================

// Module: vga_sync_gen
// PURPOSE
//  Consumes the 25 MHz pixel strobe from clock_divider and produces 640x480@60 VGA timing.
//  Outputs: hsync/vsync, active-video flag, pixel coordinates and frame/line event pulses.
//  Sits between clock_divider and the Snake renderer/game-tick logic. All logic runs on clk.
//  pix_stb is a clock enable, never a clock.
// PARAMETERS
//  H_ACTIVE  640  visible pixels per line
//  H_FP      16   horizontal front porch (pixels)
//  H_SYNC    96   hsync pulse width (pixels)
//  H_BP      48   horizontal back porch (pixels)
//  V_ACTIVE  480  visible lines per frame
//  V_FP      10   vertical front porch (lines)
//  V_SYNC    2    vsync pulse width (lines)
//  V_BP      33   vertical back porch (lines)
//  HS_POL    0    hsync asserted level (0 = active-low)
//  VS_POL    0    vsync asserted level (0 = active-low)
//  Derived localparams: H_TOTAL = sum of H_* (800); V_TOTAL = sum of V_* (525).
// PORTS
//  clk          in   1   system clock (100 MHz)
//  rst          in   1   synchronous, active-high reset
//  pix_stb      in   1   1-clk pixel enable from clock_divider (1 in 4 clks)
//  hsync        out  1   horizontal sync, polarity per HS_POL
//  vsync        out  1   vertical sync, polarity per VS_POL
//  active       out  1   1 while h_cnt<H_ACTIVE && v_cnt<V_ACTIVE
//  x            out  10  current column = h_cnt
//  y            out  10  current row = v_cnt
//  line_end     out  1   1-clk pulse: pix_stb && h_cnt==H_TOTAL-1
//  frame_end    out  1   1-clk pulse: pix_stb && h_cnt==H_TOTAL-1 && v_cnt==V_ACTIVE-1 (game tick)
// BEHAVIOUR
//  - Registered counters h_cnt, v_cnt (10 b each). Order per axis: active, FP, sync, BP.
//  - Counter update, at each posedge clk:
//    - rst=1: h_cnt=0 and v_cnt=0. rst overrides pix_stb.
//    - else if pix_stb=0: hold both counters.
//    - else if h_cnt<H_TOTAL-1: h_cnt+1, v_cnt holds.
//    - else (h_cnt==H_TOTAL-1): h_cnt=0; v_cnt = (v_cnt==V_TOTAL-1) ? 0 : v_cnt+1.
//  - Output decode: all outputs decode combinationally from the counter registers.
//    - Latency from counter register to outputs is 0 clk.
//    - line_end and frame_end additionally AND with pix_stb, so they are exactly 1 clk wide.
//  - hsync = HS_POL when h_cnt in [H_ACTIVE+H_FP, H_ACTIVE+H_FP+H_SYNC) = [656,752); else ~HS_POL.
//  - vsync = VS_POL when v_cnt in [V_ACTIVE+V_FP, V_ACTIVE+V_FP+V_SYNC) = [490,492); else ~VS_POL.
//  - Reset values: x=0, y=0, active=1, hsync=~HS_POL, vsync=~VS_POL, line_end=0, frame_end=0.
//  - Reset mid-frame: next edge returns to (0,0) regardless of pix_stb. No sync glitch beyond a level change.
//  - pix_stb held high continuously: counts every clk. Timing is simply 4x faster; this is legal.
//  - Counters never exceed H_TOTAL-1 / V_TOTAL-1. No illegal states are reachable.
//  - Widths: 10 b covers H_TOTAL/V_TOTAL up to 1024. Larger totals are unsupported.
// STRUCTURE
//  - vga_pkg holds:
//    - default 640x480 timing constants;
//    - the H_TOTAL/V_TOTAL formulas;
//    - the sync polarity constants.
//  - One sub-module: vga_axis_counter (params TOTAL, SYNC_START, SYNC_LEN, ACTIVE_LEN).
//    - Inputs: en, rst. Outputs: cnt, wrap, in_sync, in_active.
//    - Instantiated twice:
//      - horizontal: en = pix_stb;
//      - vertical: en = pix_stb && h_wrap.
//  - Top level: polarity muxing and event pulses only.
// TESTING
//  1. rst=1 for 3 clks, pix_stb toggling -> x=0, y=0, active=1, hsync=1, vsync=1, no pulses.
//  2. pix_stb every 4th clk for 1 line -> hsync low for exactly 96 strobes (x 656..751).
//     Then line_end once at x=799; next strobe gives x=0, y=1.
//  3. Full frame -> vsync low on y=490,491 only; frame_end once per frame at (799,479).
//     Frame = 420000 strobes = 1680000 clks.
//  4. pix_stb=0 for 50 clks mid-line (x=300) -> x, y, syncs frozen; resume continues at x=301.
//  5. Assert rst at (x=700, y=491) with pix_stb=1 same clk -> next edge x=0, y=0, syncs deasserted.
//  6. Wrap: at (799,524) with strobe -> (0,0); frame_end=0 on that strobe; active rises.

Source files
------------

// File: rtl/vga_pkg.sv
// Shared VGA timing constants and helpers for the 640x480@60 sync generator.
package vga_pkg;

  // Counter width; covers line/frame totals up to 1024.
  localparam int CNT_W = 10;

  // Default 640x480@60 horizontal timing, in pixels.
  localparam int H_ACTIVE_DEF = 640;
  localparam int H_FP_DEF     = 16;
  localparam int H_SYNC_DEF   = 96;
  localparam int H_BP_DEF     = 48;

  // Default 640x480@60 vertical timing, in lines.
  localparam int V_ACTIVE_DEF = 480;
  localparam int V_FP_DEF     = 10;
  localparam int V_SYNC_DEF   = 2;
  localparam int V_BP_DEF     = 33;

  // Sync asserted levels; both pulses are active-low in this mode.
  localparam logic HS_POL_DEF = 1'b0;
  localparam logic VS_POL_DEF = 1'b0;

  // Length of one axis: active, front porch, sync, back porch in that order.
  function automatic int axis_total(input int active, input int fp, input int sync, input int bp);
    return active + fp + sync + bp;
  endfunction

  localparam int H_TOTAL_DEF = axis_total(H_ACTIVE_DEF, H_FP_DEF, H_SYNC_DEF, H_BP_DEF);
  localparam int V_TOTAL_DEF = axis_total(V_ACTIVE_DEF, V_FP_DEF, V_SYNC_DEF, V_BP_DEF);

endpackage

// File: rtl/vga_axis_counter.sv
// One timing axis: a wrapping position counter plus sync/active window decode.
module vga_axis_counter
  import vga_pkg::*;
#(
  parameter int TOTAL      = H_TOTAL_DEF,
  parameter int SYNC_START = H_ACTIVE_DEF + H_FP_DEF,
  parameter int SYNC_LEN   = H_SYNC_DEF,
  parameter int ACTIVE_LEN = H_ACTIVE_DEF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  output logic [CNT_W-1:0] cnt,
  output logic             wrap,
  output logic             in_sync,
  output logic             in_active
);

  localparam logic [CNT_W-1:0] LAST       = CNT_W'(TOTAL - 1);
  localparam logic [CNT_W-1:0] SYNC_FIRST = CNT_W'(SYNC_START);
  localparam logic [CNT_W-1:0] SYNC_STOP  = CNT_W'(SYNC_START + SYNC_LEN);
  localparam logic [CNT_W-1:0] ACT_STOP   = CNT_W'(ACTIVE_LEN);

  // Advance on each enable, folding back to zero after the last position.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt <= '0;
    end else if (en) begin
      if (cnt == LAST) begin
        cnt <= '0;
      end else begin
        cnt <= cnt + CNT_W'(1);
      end
    end
  end

  // Window decode straight off the register so outputs track the count with no lag.
  assign wrap      = en && (cnt == LAST);
  assign in_sync   = (cnt >= SYNC_FIRST) && (cnt < SYNC_STOP);
  assign in_active = (cnt < ACT_STOP);

endmodule

// File: rtl/vga_sync_gen.sv
// VGA timing generator: turns the pixel strobe into syncs, coordinates and line/frame events.
module vga_sync_gen
  import vga_pkg::*;
#(
  parameter int   H_ACTIVE = H_ACTIVE_DEF,
  parameter int   H_FP     = H_FP_DEF,
  parameter int   H_SYNC   = H_SYNC_DEF,
  parameter int   H_BP     = H_BP_DEF,
  parameter int   V_ACTIVE = V_ACTIVE_DEF,
  parameter int   V_FP     = V_FP_DEF,
  parameter int   V_SYNC   = V_SYNC_DEF,
  parameter int   V_BP     = V_BP_DEF,
  parameter logic HS_POL   = HS_POL_DEF,
  parameter logic VS_POL   = VS_POL_DEF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             pix_stb,
  output logic             hsync,
  output logic             vsync,
  output logic             active,
  output logic [CNT_W-1:0] x,
  output logic [CNT_W-1:0] y,
  output logic             line_end,
  output logic             frame_end
);

  localparam int H_TOTAL = axis_total(H_ACTIVE, H_FP, H_SYNC, H_BP);
  localparam int V_TOTAL = axis_total(V_ACTIVE, V_FP, V_SYNC, V_BP);

  localparam logic [CNT_W-1:0] V_LAST_ACTIVE = CNT_W'(V_ACTIVE - 1);

  logic [CNT_W-1:0] h_cnt;
  logic [CNT_W-1:0] v_cnt;
  logic             h_wrap;
  logic             h_in_sync;
  logic             h_in_active;
  logic             v_in_sync;
  logic             v_in_active;

  // Horizontal axis steps once per pixel strobe.
  vga_axis_counter #(
    .TOTAL      (H_TOTAL),
    .SYNC_START (H_ACTIVE + H_FP),
    .SYNC_LEN   (H_SYNC),
    .ACTIVE_LEN (H_ACTIVE)
  ) u_h_axis (
    .clk       (clk),
    .rst       (rst),
    .en        (pix_stb),
    .cnt       (h_cnt),
    .wrap      (h_wrap),
    .in_sync   (h_in_sync),
    .in_active (h_in_active)
  );

  // Vertical axis steps once per line, on the strobe that ends it.
  vga_axis_counter #(
    .TOTAL      (V_TOTAL),
    .SYNC_START (V_ACTIVE + V_FP),
    .SYNC_LEN   (V_SYNC),
    .ACTIVE_LEN (V_ACTIVE)
  ) u_v_axis (
    .clk       (clk),
    .rst       (rst),
    .en        (pix_stb && h_wrap),
    .cnt       (v_cnt),
    .wrap      (),
    .in_sync   (v_in_sync),
    .in_active (v_in_active)
  );

  // Polarity muxing and coordinates.
  assign hsync  = h_in_sync ? HS_POL : ~HS_POL;
  assign vsync  = v_in_sync ? VS_POL : ~VS_POL;
  assign active = h_in_active && v_in_active;
  assign x      = h_cnt;
  assign y      = v_cnt;

  // Event pulses are strobe-qualified so each lasts exactly one clk.
  assign line_end  = pix_stb && h_wrap;
  assign frame_end = line_end && (v_cnt == V_LAST_ACTIVE);

endmodule

// File: tb/tb_vga_sync_gen.sv
// Scoreboard bench for vga_sync_gen: a full-size instance for line timing and a
// shrunken instance for frame-level timing, both driven by the same inputs.
module tb_vga_sync_gen;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       pix_stb = 1'b0;

  logic [9:0] x_d, y_d, x_s, y_s;
  logic       hs_d, vs_d, act_d, le_d, fe_d;
  logic       hs_s, vs_s, act_s, le_s, fe_s;

  int         cyc = 0;
  int         total = 0;
  int         bad = 0;

  typedef struct {
    int    cyc;
    int    sel;
    string name;
    int    x;
    int    y;
    logic  act;
    logic  hs;
    logic  vs;
    logic  le;
    logic  fe;
  } exp_t;

  exp_t sbq[$];
  exp_t mon_e;

  logic [9:0] ax, ay;
  logic       aa, ah, av, al, af;

  bit win_d = 0;
  bit win_s = 0;
  int hs_low_d = 0, le_cnt_d = 0, fe_cnt_d = 0;
  int hs_low_s = 0, vs_low_s = 0, le_cnt_s = 0, fe_cnt_s = 0;

  // Hand-computed checkpoints along one full-size line: x, active, hsync.
  int   pt_x   [10] = '{0, 300, 301, 639, 640, 655, 656, 751, 752, 799};
  logic pt_act [10] = '{1,   1,   1,   1,   0,   0,   0,   0,   0,   0};
  logic pt_hs  [10] = '{1,   1,   1,   1,   1,   1,   0,   0,   1,   1};

  // Small instance: H 8/2/3/2 (total 15), V 6/2/2/3 (total 13), strobe every clk.
  int   sp_n  [17] = '{0, 7, 8, 9, 10, 12, 13, 14, 77, 89, 90, 105, 120, 149, 150, 194, 195};
  int   sp_x  [17] = '{0, 7, 8, 9, 10, 12, 13, 14,  2, 14,  0,   0,   0,  14,   0,  14,   0};
  int   sp_y  [17] = '{0, 0, 0, 0,  0,  0,  0,  0,  5,  5,  6,   7,   8,   9,  10,  12,   0};
  logic sp_a  [17] = '{1, 1, 0, 0,  0,  0,  0,  0,  1,  0,  0,   0,   0,   0,   0,   0,   1};
  logic sp_h  [17] = '{1, 1, 1, 1,  0,  0,  1,  1,  1,  1,  1,   1,   1,   1,   1,   1,   1};
  logic sp_v  [17] = '{1, 1, 1, 1,  1,  1,  1,  1,  1,  1,  1,   1,   0,   0,   1,   1,   1};
  logic sp_l  [17] = '{0, 0, 0, 0,  0,  0,  0,  1,  0,  1,  0,   0,   0,   1,   0,   1,   0};
  logic sp_f  [17] = '{0, 0, 0, 0,  0,  0,  0,  0,  0,  1,  0,   0,   0,   0,   0,   0,   0};

  vga_sync_gen dut (
    .clk       (clk),
    .rst       (rst),
    .pix_stb   (pix_stb),
    .hsync     (hs_d),
    .vsync     (vs_d),
    .active    (act_d),
    .x         (x_d),
    .y         (y_d),
    .line_end  (le_d),
    .frame_end (fe_d)
  );

  vga_sync_gen #(
    .H_ACTIVE (8),
    .H_FP     (2),
    .H_SYNC   (3),
    .H_BP     (2),
    .V_ACTIVE (6),
    .V_FP     (2),
    .V_SYNC   (2),
    .V_BP     (3)
  ) dut_s (
    .clk       (clk),
    .rst       (rst),
    .pix_stb   (pix_stb),
    .hsync     (hs_s),
    .vsync     (vs_s),
    .active    (act_s),
    .x         (x_s),
    .y         (y_s),
    .line_end  (le_s),
    .frame_end (fe_s)
  );

  // 100 MHz-style clock, posedge at 5, 15, ...
  always #5 clk = ~clk;

  // Cycle stamp used to line up queued expectations with the sampling edge.
  always @(posedge clk) cyc <= cyc + 1;

  // Monitor: mid-cycle, tally event windows and retire every expectation due this cycle.
  always @(negedge clk) begin
    if (win_d) begin
      if (pix_stb && !hs_d) hs_low_d++;
      if (le_d) le_cnt_d++;
      if (fe_d) fe_cnt_d++;
    end
    if (win_s) begin
      if (pix_stb && !hs_s) hs_low_s++;
      if (pix_stb && !vs_s) vs_low_s++;
      if (le_s) le_cnt_s++;
      if (fe_s) fe_cnt_s++;
    end
    while (sbq.size() > 0 && sbq[0].cyc <= cyc) begin
      mon_e = sbq.pop_front();
      total++;
      if (mon_e.sel == 0) begin
        ax = x_d; ay = y_d; aa = act_d; ah = hs_d; av = vs_d; al = le_d; af = fe_d;
      end else begin
        ax = x_s; ay = y_s; aa = act_s; ah = hs_s; av = vs_s; al = le_s; af = fe_s;
      end
      if (mon_e.cyc != cyc) begin
        bad++;
        $display("[TB] FAIL %s: expectation for cycle %0d sampled late at cycle %0d",
                 mon_e.name, mon_e.cyc, cyc);
      end else if (ax !== 10'(mon_e.x) || ay !== 10'(mon_e.y) || aa !== mon_e.act ||
                   ah !== mon_e.hs || av !== mon_e.vs || al !== mon_e.le || af !== mon_e.fe) begin
        bad++;
        $display("[TB] FAIL %s cyc=%0d got x=%0d y=%0d act=%b hs=%b vs=%b le=%b fe=%b want x=%0d y=%0d act=%b hs=%b vs=%b le=%b fe=%b",
                 mon_e.name, cyc, ax, ay, aa, ah, av, al, af,
                 mon_e.x, mon_e.y, mon_e.act, mon_e.hs, mon_e.vs, mon_e.le, mon_e.fe);
      end
    end
  end

  // Drive inputs for the coming cycle.
  task automatic applyStimulus(input logic r, input logic s);
    rst     = r;
    pix_stb = s;
  endtask

  // Advance past the next active edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Queue the outputs expected during the current cycle.
  task automatic checkOutput(input string name, input int sel, input int ex, input int ey,
                             input logic ea, input logic ehs, input logic evs,
                             input logic ele, input logic efe);
    exp_t e;
    e.cyc = cyc; e.sel = sel; e.name = name;
    e.x = ex; e.y = ey; e.act = ea; e.hs = ehs; e.vs = evs; e.le = ele; e.fe = efe;
    sbq.push_back(e);
  endtask

  // Direct comparison of an aggregate count.
  task automatic checkCount(input string name, input int got, input int want);
    total++;
    if (got != want) begin
      bad++;
      $display("[TB] FAIL %s got=%0d want=%0d", name, got, want);
    end
  endtask

  // Watchdog: never let the run hang.
  initial begin
    #500000;
    $display("[TB] FAIL watchdog: run did not complete, queue=%0d", sbq.size());
    $display("test done: total=%0d bad=%0d", total, bad + 1);
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int pi;
    int zc;

    applyStimulus(1'b1, 1'b0);
    tick();

    // Reset held with the strobe toggling.
    for (int i = 0; i < 3; i++) begin
      applyStimulus(1'b1, (i % 2) == 0);
      checkOutput("reset_d", 0, 0, 0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0);
      checkOutput("reset_s", 1, 0, 0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0);
      tick();
    end

    // One full-size line with a strobe every 4th clk and a 50-clk stall at x=300.
    win_d = 1;
    for (int k = 0; k < 800; k++) begin
      pi = -1;
      for (int j = 0; j < 10; j++) if (pt_x[j] == k) pi = j;
      zc = (k == 300) ? 50 : 3;
      for (int z = 0; z < zc; z++) begin
        applyStimulus(1'b0, 1'b0);
        if (pi >= 0 && (z == 0 || z == zc - 1))
          checkOutput("line_idle", 0, k, 0, pt_act[pi], pt_hs[pi], 1'b1, 1'b0, 1'b0);
        tick();
      end
      applyStimulus(1'b0, 1'b1);
      if (pi >= 0)
        checkOutput("line_stb", 0, k, 0, pt_act[pi], pt_hs[pi], 1'b1, k == 799, 1'b0);
      tick();
    end
    win_d = 0;
    applyStimulus(1'b0, 1'b0);
    checkOutput("line_wrap", 0, 0, 1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0);
    tick();
    checkCount("hsync_low_strobes", hs_low_d, 96);
    checkCount("line_end_pulses", le_cnt_d, 1);
    checkCount("frame_end_pulses_line", fe_cnt_d, 0);

    // Small instance: clear, then one whole frame with the strobe held high.
    applyStimulus(1'b1, 1'b1);
    tick();
    win_s = 1;
    for (int n = 0; n < 342; n++) begin
      if (n == 195) win_s = 0;
      pi = -1;
      for (int j = 0; j < 17; j++) if (sp_n[j] == n) pi = j;
      if (n == 341) begin
        applyStimulus(1'b1, 1'b1);
        checkOutput("reset_mid_sync", 1, 11, 9, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
      end else begin
        applyStimulus(1'b0, 1'b1);
        if (pi >= 0)
          checkOutput("frame_pt", 1, sp_x[pi], sp_y[pi], sp_a[pi], sp_h[pi], sp_v[pi],
                      sp_l[pi], sp_f[pi]);
      end
      tick();
    end
    applyStimulus(1'b0, 1'b0);
    checkOutput("after_reset_s", 1, 0, 0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0);
    checkOutput("after_reset_d", 0, 0, 0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0);
    tick();
    checkCount("frame_vsync_low_strobes", vs_low_s, 30);
    checkCount("frame_hsync_low_strobes", hs_low_s, 39);
    checkCount("frame_line_end_pulses", le_cnt_s, 13);
    checkCount("frame_end_pulses", fe_cnt_s, 1);

    tick();
    tick();
    checkCount("queue_drained", sbq.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
